// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the RW port of the 32x256 OpenRAM macro between m0 and m1.
// Optional grant/conflict performance counters are enabled with `define SRAM_ARB_PERF_EN.
module sram_rw_port_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [NUM_WMASKS-1:0] m0_wmask,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [NUM_WMASKS-1:0] m1_wmask,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  init_done,

`ifdef SRAM_ARB_PERF_EN
  output logic [31:0]           m0_gnt_cnt,
  output logic [31:0]           m1_gnt_cnt,
  output logic [31:0]           conflict_cnt,
`endif

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t                  RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                    last_gnt_reg, last_gnt_next;

  // Requester attributes gathered into arrays so the winner can be muxed by index.
  logic [1:0]              req_vec;
  logic [1:0]              we_vec;
  logic [1:0]              gnt_vec;
  logic [ADDR_WIDTH-1:0]   addr_arr  [2];
  logic [NUM_WMASKS-1:0]   wmask_arr [2];
  logic [DATA_WIDTH-1:0]   wdata_arr [2];
  logic                    rvalid_reg [2];
  logic                    win_sel;
  logic                    win_any;

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wmask_arr[0] = m0_wmask;
  assign wmask_arr[1] = m1_wmask;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RESET_STATE;
      cnt_reg      <= '0;
      last_gnt_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

  // Everything is gated by rst so reset takes effect on the macro pins immediately,
  // not at the next edge.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_gnt_next = last_gnt_reg;
    win_sel       = 1'b0;
    win_any       = 1'b0;
    gnt_vec       = 2'b00;
    init_done     = 1'b0;
    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_wmask0   = '0;
    sram_addr0    = '0;
    sram_din0     = '0;

    if (!rst) begin
      case (state_reg)
        ST_INIT: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = cnt_reg;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == LAST_ADDR) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          // m0 wins a tie unless it was the last one served.
          if (req_vec[0] && (!req_vec[1] || last_gnt_reg)) begin
            win_sel = 1'b0;
            win_any = 1'b1;
          end else if (req_vec[1]) begin
            win_sel = 1'b1;
            win_any = 1'b1;
          end
          if (win_any) begin
            gnt_vec[win_sel] = 1'b1;
            last_gnt_next    = win_sel;
            sram_csb0        = 1'b0;
            sram_web0        = ~we_vec[win_sel];
            sram_wmask0      = wmask_arr[win_sel];
            sram_addr0       = addr_arr[win_sel];
            sram_din0        = wdata_arr[win_sel];
          end
        end
        default: begin
          state_next = RESET_STATE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rvalid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
        end else begin
          rvalid_reg[gi] <= gnt_vec[gi] & ~we_vec[gi];
        end
      end
    end
  endgenerate

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_reg[0];
  assign m1_rvalid = rvalid_reg[1];
  // The macro drives dout0 one cycle after the grant, exactly while rvalid is high.
  assign m0_rdata  = sram_dout0;
  assign m1_rdata  = sram_dout0;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] gnt_cnt_reg [2];
  logic [31:0] conflict_cnt_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          gnt_cnt_reg[gi] <= '0;
        end else if (gnt_vec[gi] && (gnt_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if ((state_reg == ST_RUN) && (&req_vec) && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign m0_gnt_cnt   = gnt_cnt_reg[0];
  assign m1_gnt_cnt   = gnt_cnt_reg[1];
  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural model of the OpenRAM RW port.
module tb_sram_rw_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [7:0]  m0_addr = '0;
  logic [3:0]  m0_wmask = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0]  m1_addr = '0;
  logic [3:0]  m1_wmask = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        init_done;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_rw_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wmask    (m0_wmask),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wmask    (m1_wmask),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .init_done   (init_done),
`ifdef SRAM_ARB_PERF_EN
    .m0_gnt_cnt  (m0_gnt_cnt),
    .m1_gnt_cnt  (m1_gnt_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Macro model: inputs captured at posedge, array access on the following negedge.
  logic [31:0] mem [256];
  logic        mdl_csb = 1'b1, mdl_web = 1'b1;
  logic [3:0]  mdl_wmask = '0;
  logic [7:0]  mdl_addr = '0;
  logic [31:0] mdl_din = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
  end

  always @(posedge clk) begin
    mdl_csb   <= sram_csb0;
    mdl_web   <= sram_web0;
    mdl_wmask <= sram_wmask0;
    mdl_addr  <= sram_addr0;
    mdl_din   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!mdl_csb) begin
      if (!mdl_web) begin
        for (int b = 0; b < 4; b++)
          if (mdl_wmask[b]) mem[mdl_addr][8*b +: 8] <= mdl_din[8*b +: 8];
      end else begin
        sram_dout0 <= mem[mdl_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at negedge+1; presents one request, checks its grant and the response.
  task automatic issue(input string tag, input bit m, input logic we, input logic [7:0] a,
                       input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp_rd);
    if (!m) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wmask = wm; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wmask = wm; m1_wdata = wd;
    end
    #1;
    $display("[TB] %s: m%0d %s addr=0x%0h wmask=0x%0h wdata=0x%0h", tag, m, we ? "WR" : "RD", a, wm, wd);
    check({tag, " gnt"}, m ? m1_gnt : m0_gnt, 1);
    check({tag, " other_gnt"}, m ? m0_gnt : m1_gnt, 0);
    check({tag, " csb0"}, sram_csb0, 0);
    check({tag, " web0"}, sram_web0, we ? 1'b0 : 1'b1);
    check({tag, " addr0"}, sram_addr0, a);
    if (we) begin
      check({tag, " wmask0"}, sram_wmask0, wm);
      check({tag, " din0"}, sram_din0, wd);
    end
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    #1;
    check({tag, " rvalid"}, m ? m1_rvalid : m0_rvalid, !we);
    check({tag, " other_rvalid"}, m ? m0_rvalid : m1_rvalid, 0);
    if (!we) check({tag, " rdata"}, m ? m1_rdata : m0_rdata, exp_rd);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (n < 300 && init_done !== 1'b1) begin
      @(posedge clk);
      n++;
      #1;
    end
    $display("[TB] %s: init_done after %0d cycles", tag, n);
    check({tag, " init_cycles"}, n, 256);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst csb0", sram_csb0, 1);
    check("rst web0", sram_web0, 1);
    check("rst wmask0", sram_wmask0, 0);
    check("rst addr0", sram_addr0, 0);
    check("rst din0", sram_din0, 0);
    check("rst init_done", init_done, 0);
    check("rst gnt", {m1_gnt, m0_gnt}, 0);
    check("rst rvalid", {m1_rvalid, m0_rvalid}, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init0 csb0", sram_csb0, 0);
    check("init0 web0", sram_web0, 0);
    check("init0 wmask0", sram_wmask0, 4'hF);
    check("init0 addr0", sram_addr0, 0);
    check("init0 din0", sram_din0, 0);
    wait_init("init1");

    issue("rd_ff",     1'b0, 1'b0, 8'hFF, 4'h0, 32'h0,         32'h0000_0000);
    issue("wr10_m0",   1'b0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF,  32'h0);
    issue("raw10_m0",  1'b0, 1'b0, 8'h10, 4'h0, 32'h0,         32'hDEADBEEF);
    issue("wr10_m1",   1'b1, 1'b1, 8'h10, 4'h2, 32'h0000AB00,  32'h0);
    issue("rd10_m1",   1'b1, 1'b0, 8'h10, 4'h0, 32'h0,         32'hDEADABEF);
    issue("wr10_nomask", 1'b0, 1'b1, 8'h10, 4'h0, 32'hFFFFFFFF, 32'h0);
    issue("rd10_m0",   1'b0, 1'b0, 8'h10, 4'h0, 32'h0,         32'hDEADABEF);
    issue("rd11_m1",   1'b1, 1'b0, 8'h11, 4'h0, 32'h0,         32'h0000_0000);
    issue("wr20_m0",   1'b0, 1'b1, 8'h20, 4'hF, 32'h11112222,  32'h0);
    issue("wr21_m1",   1'b1, 1'b1, 8'h21, 4'hF, 32'h33334444,  32'h0);

    check("idle csb0", sram_csb0, 1);
    check("idle web0", sram_web0, 1);
    check("idle addr0", sram_addr0, 0);

    // Both masters keep reading: m0 is due first since m1 was served last.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h21;
    for (int c = 0; c < 4; c++) begin
      #1;
      $display("[TB] contend c=%0d: m0_gnt=%0b m1_gnt=%0b m0_rvalid=%0b m1_rvalid=%0b",
               c, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
      check("cont m0_gnt", m0_gnt, (c % 2 == 0));
      check("cont m1_gnt", m1_gnt, (c % 2 == 1));
      check("cont m0_rvalid", m0_rvalid, (c % 2 == 1));
      check("cont m1_rvalid", m1_rvalid, (c != 0) && (c % 2 == 0));
      if (c % 2 == 1) check("cont m0_rdata", m0_rdata, 32'h11112222);
      if (c != 0 && c % 2 == 0) check("cont m1_rdata", m1_rdata, 32'h33334444);
      @(negedge clk);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    #1;
    check("cont tail m1_rvalid", m1_rvalid, 1);
    check("cont tail m0_rvalid", m0_rvalid, 0);
    check("cont tail m1_rdata", m1_rdata, 32'h33334444);
    @(negedge clk);
    #1;
    check("cont end rvalid", {m1_rvalid, m0_rvalid}, 0);
`ifdef SRAM_ARB_PERF_EN
    check("perf m0_gnt_cnt", m0_gnt_cnt, 8);
    check("perf m1_gnt_cnt", m1_gnt_cnt, 6);
    check("perf conflict_cnt", conflict_cnt, 4);
`endif

    // Reset while running with a pending request, then again in the middle of INIT.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
    rst = 1'b1;
    #1;
    $display("[TB] reset in RUN");
    check("rrun gnt", m0_gnt, 0);
    check("rrun csb0", sram_csb0, 1);
    check("rrun init_done", init_done, 0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    #1;
    check("init40 addr0", sram_addr0, 8'h40);
    check("init40 csb0", sram_csb0, 0);
    rst = 1'b1;
    #1;
    $display("[TB] reset in INIT at addr 0x40");
    check("rinit csb0", sram_csb0, 1);
    check("rinit web0", sram_web0, 1);
    check("rinit addr0", sram_addr0, 0);
    check("rinit init_done", init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("restart addr0", sram_addr0, 0);
    check("restart csb0", sram_csb0, 0);
`ifdef SRAM_ARB_PERF_EN
    check("perf clr m0_gnt_cnt", m0_gnt_cnt, 0);
    check("perf clr conflict_cnt", conflict_cnt, 0);
`endif
    wait_init("init2");
    issue("rd10_clr", 1'b0, 1'b0, 8'h10, 4'h0, 32'h0, 32'h0000_0000);
`ifdef SRAM_ARB_PERF_EN
    check("perf post m0_gnt_cnt", m0_gnt_cnt, 1);
    check("perf post m1_gnt_cnt", m1_gnt_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rw_port_arbiter.md
Name: sram_rw_port_arbiter

Overview:
Shares the single RW port (port 0) of the 32x256 OpenRAM SRAM macro between two requesters, m0 and m1, using round-robin arbitration.
- Drives the macro's csb0/web0/wmask0/addr0/din0 and returns dout0 with fixed one-cycle read latency.
- Optionally zero-fills the whole array after reset before granting any request.
- Sits between the core's bus masters and the macro. The read-only port 1 is not touched.

Parameters:
- ADDR_WIDTH, 8, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte write-enable count (DATA_WIDTH/8).
- RAM_DEPTH, 1<<ADDR_WIDTH, words to clear during INIT.
- CLEAR_ON_RESET, 1, 1 = run the INIT zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock; also drives the macro's clk0.
- rst  in  1  asynchronous, active-high reset.
- mX_req  in  1  request, X in {0,1}; held with its attributes until granted.
- mX_we  in  1  1 = write, 0 = read.
- mX_addr  in  ADDR_WIDTH  word address.
- mX_wmask  in  NUM_WMASKS  byte enables for writes.
- mX_wdata  in  DATA_WIDTH  write data.
- mX_gnt  out  1  request accepted at this posedge (combinational).
- mX_rvalid  out  1  read data valid this cycle (registered pulse).
- mX_rdata  out  DATA_WIDTH  read data; meaningful only while mX_rvalid.
- init_done  out  1  high once in RUN.
- sram_csb0  out  1  to macro, active-low chip select.
- sram_web0  out  1  to macro, active-low write enable.
- sram_wmask0  out  NUM_WMASKS  to macro.
- sram_addr0  out  ADDR_WIDTH  to macro.
- sram_din0  out  DATA_WIDTH  to macro.
- sram_dout0  in  DATA_WIDTH  from macro.

Behaviour:
- Reset is asynchronous and immediate. Resulting values: state=INIT (RUN if CLEAR_ON_RESET=0), init counter=0, last_gnt=1 (so m0 wins the first contention), sram_csb0=1, sram_web0=1, sram_wmask0/addr0/din0=0, mX_gnt=0, mX_rvalid=0, init_done=0.
- Reset mid-operation aborts any in-flight read (no rvalid is issued) and restarts INIT from address 0.
- Macro outputs are combinational from the state and the granted request; the macro registers them at the posedge.
- INIT state: each cycle drives csb0=0, web0=0, wmask0=all ones, din0=0, addr0=cnt.
  - cnt increments every cycle; after cnt=RAM_DEPTH-1 the FSM moves to RUN.
  - INIT therefore lasts exactly RAM_DEPTH cycles. No grants are issued and init_done=0.
- RUN state: init_done=1; mX_gnt=mX_req when only one requester is active.
  - When both request, grant the requester that is not last_gnt.
  - last_gnt updates on every grant. Exactly one grant per cycle at most.
  - Granted cycle: csb0=0, web0=~we, plus addr/wmask/wdata of the winner.
  - Idle cycle: csb0=1, web0=1, other macro outputs 0.
- Read latency: a read granted at posedge N gives mX_rvalid=1 for exactly the cycle N..N+1. mX_rdata=sram_dout0 (the macro updates dout0 on the negedge after N).
  - rvalid has no backpressure; the requester must accept it.
  - Back-to-back reads from one requester give back-to-back rvalid pulses.
- Writes complete at grant; there is no response. A write with wmask=0 is still granted and the array is unchanged.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data, because the macro writes on the negedge.
- A non-granted requester must hold req and its attributes. Dropping req before grant is legal; the request is then abandoned.

Optional Feature:
Macro SRAM_ARB_PERF_EN.
- Defined: adds outputs m0_gnt_cnt[31:0], m1_gnt_cnt[31:0] and conflict_cnt[31:0].
  - Each mX_gnt_cnt counts that requester's grants.
  - conflict_cnt counts RUN cycles in which both req are high.
  - All three saturate at 0xFFFFFFFF, clear on rst and do not count during INIT.
- Undefined: these ports and registers do not exist.

Test Plan:
- CLEAR_ON_RESET=1, release rst: init_done rises exactly 256 cycles after release; m0 read 0xFF -> m0_rvalid next cycle with rdata 0x00000000.
- m0 write addr 0x10, data 0xDEADBEEF, wmask 4'b1111; next cycle m0 read 0x10 -> rvalid one cycle after grant with 0xDEADBEEF.
- m1 write 0x10, data 0x0000AB00, wmask 4'b0010; then read 0x10 -> 0xDEADABEF.
- m0 and m1 both issue reads of 0x20/0x21 for 4 cycles -> grants go m0, m1, m0, m1; each rvalid lands one cycle after its own grant; m1_rvalid never overlaps m0_rvalid.
- Assert rst during INIT at cnt=0x40 -> csb0=1 and init_done=0 immediately; after release INIT restarts at addr 0 and init_done rises 256 cycles later.
- SRAM_ARB_PERF_EN defined, repeat the contention test -> m0_gnt_cnt=2, m1_gnt_cnt=2, conflict_cnt=4.
